tree_sequencer: RTL
===================

TREE_SEQUENCER -- requirements
Module: tree_sequencer

Interface
REQ-001 Parameter COMMAND_SIZE, default 5, SHALL set the command bus width.
REQ-002 Parameter DATA_SIZE, default 24, SHALL set the data bus width.
REQ-003 Parameter AXIS_SIZE, default 2, SHALL set the sort-axis width.
REQ-004 Parameter TIMEOUT, default 1023, SHALL set the maximum cycles spent waiting in any one phase.
REQ-005 Ports SHALL be as follows, clock and reset first:
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  reset, synchronous, active-high
 start  in  1  one-cycle pulse that begins a build/sort pass
 axis  in  AXIS_SIZE  initial sort axis
 center_data  in  DATA_SIZE  next center to load
 center_valid  in  1  center_data is valid this cycle
 center_ready  out  1  center consumed this cycle
 command_to_root  out  COMMAND_SIZE  command into tree root, top side
 data_to_root  out  DATA_SIZE  data into tree root, top side
 command_from_root  in  COMMAND_SIZE  root's command to top
 data_from_root  in  DATA_SIZE  root's data to top
 busy  out  1  pass in progress
 done  out  1  one-cycle pulse, pass completed
 error  out  1  phase timeout, sticky until rst or start
 root_center  out  DATA_SIZE  root center latched at valid_sort

Function
REQ-006 Command encodings SHALL match the tree protocol: nop 00, rst 1F, rst_done 1E, center_fill 01, center_fill_done 05, configure_sort_axis 02, configure_sort_axis_done 07, start_sorting 09, ready_to_sort 0A, valid_sort 0F.
REQ-007 The FSM states SHALL be IDLE, TREE_RST, FILL, CONFIG, SORT, FINISH, ERR.
REQ-008 In IDLE, start SHALL move the FSM to TREE_RST; start SHALL be ignored in every other state except ERR.
REQ-009 TREE_RST SHALL drive rst with data 0 until command_from_root==rst_done, then go to FILL.
REQ-010 FILL SHALL drive center_fill with data_to_root=center_data and center_ready=1 in each cycle where center_valid=1, and SHALL drive nop with center_ready=0 otherwise.
REQ-011 FILL SHALL go to CONFIG when command_from_root==center_fill_done; center_ready SHALL be 0 in that cycle.
REQ-012 CONFIG SHALL drive configure_sort_axis with data_to_root = axis zero-extended until configure_sort_axis_done, then go to SORT.
REQ-013 SORT SHALL drive start_sorting with the zero-extended axis for exactly one cycle, then nop, and SHALL wait for command_from_root==valid_sort; ready_to_sort and other codes SHALL NOT end the wait.
REQ-014 On valid_sort, root_center SHALL capture data_from_root, and the FSM SHALL go to FINISH.
REQ-015 FINISH SHALL pulse done for one cycle, drive nop, and return to IDLE.
REQ-016 Each of TREE_RST, FILL, CONFIG and SORT SHALL clear a 16-bit phase counter on entry and increment it every cycle; reaching TIMEOUT SHALL move the FSM to ERR.
REQ-017 ERR SHALL drive nop, assert error, and leave on start to TREE_RST, which clears error.
REQ-018 busy SHALL be 1 in TREE_RST, FILL, CONFIG and SORT, and 0 otherwise.
REQ-019 command_to_root and data_to_root SHALL be registered: the first command of a state appears on the edge after the state is entered.
REQ-020 Root responses SHALL be sampled directly, with no synchronizer, because the clock domain is the same.
REQ-021 When a done response and a timeout occur in the same cycle, the response SHALL take priority.

Reset
REQ-022 When rst=1, the next edge SHALL set the state to IDLE, command_to_root=nop, data_to_root=0, center_ready=0, busy=0, done=0, error=0, root_center=0 and the phase counter to 0.
REQ-023 Reset asserted mid-pass SHALL abort the pass without completing the current phase; no further center SHALL be consumed.

Structure
REQ-024 Command encodings, COMMAND_SIZE, DATA_SIZE and AXIS_SIZE SHALL live in shared package kd_tree_pkg, also used by the tree node.
REQ-025 The phase timeout counter SHALL be a sub-module named phase_timer, with ports clear, expire and the TIMEOUT parameter.

Verification
REQ-026 Nominal pass: start; model replies rst_done at cycle 3 and center_fill_done after 3 centers (0x0A0B0C, 0x101010, 0x202020); configure_sort_axis_done follows; valid_sort arrives with data 0x101010 -> root_center=0x101010, done pulses once, busy returns to 0.
REQ-027 Fill stall: center_valid low for 2 cycles mid-fill -> command_to_root=nop and center_ready=0 for exactly those 2 cycles, with no center lost or duplicated.
REQ-028 Timeout: TIMEOUT=8, model never sends rst_done -> ERR after 8 cycles, error=1, nop driven; a subsequent start clears error and re-enters TREE_RST.
REQ-029 Reset mid-FILL after 1 center -> next cycle IDLE with all outputs at reset values; center_ready=0 thereafter.
REQ-030 Sort wait: model sends ready_to_sort for 5 cycles, then valid_sort -> no done until valid_sort; start_sorting appears exactly once.
REQ-031 start pulsed during CONFIG -> ignored, and the pass completes normally.

Source files
------------

// File: rtl/kd_tree_pkg.sv
// kd_tree_pkg: bus widths, tree command encodings and sequencer states shared by the sequencer and tree nodes
package kd_tree_pkg;
  localparam int COMMAND_SIZE = 5;
  localparam int DATA_SIZE = 24;
  localparam int AXIS_SIZE = 2;
  localparam logic [4:0] CMD_NOP = 5'h00;
  localparam logic [4:0] CMD_RST = 5'h1F;
  localparam logic [4:0] CMD_RST_DONE = 5'h1E;
  localparam logic [4:0] CMD_CENTER_FILL = 5'h01;
  localparam logic [4:0] CMD_CENTER_FILL_DONE = 5'h05;
  localparam logic [4:0] CMD_CONFIGURE_SORT_AXIS = 5'h02;
  localparam logic [4:0] CMD_CONFIGURE_SORT_AXIS_DONE = 5'h07;
  localparam logic [4:0] CMD_START_SORTING = 5'h09;
  localparam logic [4:0] CMD_READY_TO_SORT = 5'h0A;
  localparam logic [4:0] CMD_VALID_SORT = 5'h0F;
  typedef enum logic [2:0] {IDLE, TREE_RST, FILL, CONFIG, SORT, FINISH, ERR} seq_state_e;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: counts cycles spent in the current phase and flags when TIMEOUT cycles have elapsed
// ports: clk, rst (sync, active-high); clear restarts the count at 0; expire is high in the TIMEOUT-th cycle
module phase_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);
  logic [15:0] count;
  always_ff @(posedge clk)
    count <= (rst || clear) ? '0 : (count == '1 ? count : count + 16'd1);
  assign expire = count >= 16'(TIMEOUT - 1);
endmodule

// File: rtl/tree_sequencer.sv
// tree_sequencer: drives a kd-tree root through reset, center fill, axis configuration and sort
// ports: clk, rst (sync, active-high); start pulse and axis begin a pass; center_data/valid/ready load centers;
//        command/data_to_root are registered commands into the root, command/data_from_root its replies;
//        busy while a phase runs, done pulses at completion, error after a phase timeout, root_center from valid_sort
module tree_sequencer #(
  parameter int COMMAND_SIZE = kd_tree_pkg::COMMAND_SIZE,
  parameter int DATA_SIZE = kd_tree_pkg::DATA_SIZE,
  parameter int AXIS_SIZE = kd_tree_pkg::AXIS_SIZE,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [AXIS_SIZE-1:0]    axis,
  input  logic [DATA_SIZE-1:0]    center_data,
  input  logic                    center_valid,
  output logic                    center_ready,
  output logic [COMMAND_SIZE-1:0] command_to_root,
  output logic [DATA_SIZE-1:0]    data_to_root,
  input  logic [COMMAND_SIZE-1:0] command_from_root,
  input  logic [DATA_SIZE-1:0]    data_from_root,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [DATA_SIZE-1:0]    root_center
);
  import kd_tree_pkg::*;
  localparam logic [COMMAND_SIZE-1:0] C_NOP = COMMAND_SIZE'(CMD_NOP);
  localparam logic [COMMAND_SIZE-1:0] C_RST = COMMAND_SIZE'(CMD_RST);
  localparam logic [COMMAND_SIZE-1:0] C_RST_DONE = COMMAND_SIZE'(CMD_RST_DONE);
  localparam logic [COMMAND_SIZE-1:0] C_FILL = COMMAND_SIZE'(CMD_CENTER_FILL);
  localparam logic [COMMAND_SIZE-1:0] C_FILL_DONE = COMMAND_SIZE'(CMD_CENTER_FILL_DONE);
  localparam logic [COMMAND_SIZE-1:0] C_AXIS = COMMAND_SIZE'(CMD_CONFIGURE_SORT_AXIS);
  localparam logic [COMMAND_SIZE-1:0] C_AXIS_DONE = COMMAND_SIZE'(CMD_CONFIGURE_SORT_AXIS_DONE);
  localparam logic [COMMAND_SIZE-1:0] C_SORT = COMMAND_SIZE'(CMD_START_SORTING);
  localparam logic [COMMAND_SIZE-1:0] C_VALID = COMMAND_SIZE'(CMD_VALID_SORT);
  seq_state_e state;
  logic sent, expire, phase_done;
  assign busy = state inside {TREE_RST, FILL, CONFIG, SORT};
  assign done = state == FINISH;
  assign error = state == ERR;
  // a root reply ending the current phase; checked ahead of expire so a reply in the timeout cycle wins
  assign phase_done = (state == TREE_RST && command_from_root == C_RST_DONE) ||
                      (state == FILL && command_from_root == C_FILL_DONE) ||
                      (state == CONFIG && command_from_root == C_AXIS_DONE) ||
                      (state == SORT && command_from_root == C_VALID);
  // gated by rst so nothing is consumed in the cycle a reset aborts the pass
  assign center_ready = !rst && state == FILL && center_valid && command_from_root != C_FILL_DONE;
  phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(!busy || phase_done || expire),
    .expire(expire)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      command_to_root <= C_NOP;
      data_to_root <= '0;
      root_center <= '0;
      sent <= 1'b0;
    end else begin
      command_to_root <= C_NOP;
      data_to_root <= '0;
      case (state)
        IDLE, ERR: state <= start ? TREE_RST : state;
        TREE_RST: begin
          command_to_root <= C_RST;
          state <= phase_done ? FILL : expire ? ERR : TREE_RST;
        end
        FILL: begin
          command_to_root <= center_ready ? C_FILL : C_NOP;
          data_to_root <= center_ready ? center_data : '0;
          state <= phase_done ? CONFIG : expire ? ERR : FILL;
        end
        CONFIG: begin
          command_to_root <= C_AXIS;
          data_to_root <= DATA_SIZE'(axis);
          sent <= 1'b0;
          state <= phase_done ? SORT : expire ? ERR : CONFIG;
        end
        SORT: begin
          command_to_root <= sent ? C_NOP : C_SORT;
          data_to_root <= sent ? '0 : DATA_SIZE'(axis);
          sent <= 1'b1;
          root_center <= phase_done ? data_from_root : root_center;
          state <= phase_done ? FINISH : expire ? ERR : SORT;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
